piso_shift_tx: RTL and testbench

- Parallel-in, serial-out transmitter. Takes a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock, MSB first, with a per-bit valid and an end-of-word strobe.
- Transmit end of the team's serial bit-stream link. The matching receive side deserialises sout/sout_valid/sout_last back into words.
- Built from rst-cleared flops, with a small FSM and a bit counter.

---
 rtl/piso_shift_tx.sv | 84 ++++++++
 tb/tb_piso_shift_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: one WIDTH-bit word per frame, MSB first.
// Define PISO_PARITY_EN to append an even-parity bit after the data LSB.
module piso_shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [FRAME-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [FRAME-1:0] load_word;
  logic             accept;

  function automatic logic [FRAME-1:0] frame_word(input logic [WIDTH-1:0] w);
`ifdef PISO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // A new word may enter while idle or on the final bit of the current frame,
  // which lets consecutive frames abut with no gap.
  assign din_ready = (state == IDLE) || ((state == SHIFT) && sout_last);
  assign accept    = din_valid && din_ready;
  assign load_word = frame_word(din);
  assign cnt_next  = cnt + 1'b1;

  // shreg holds the bits still to be sent after the one currently on sout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      sout       <= load_word[FRAME-1];
      shreg      <= {load_word[FRAME-2:0], 1'b0};
      cnt        <= '0;
      sout_valid <= 1'b1;
      sout_last  <= 1'b0;
    end else if (state == SHIFT) begin
      if (sout_last) begin
        state      <= IDLE;
        cnt        <= '0;
        sout       <= 1'b0;
        sout_valid <= 1'b0;
        sout_last  <= 1'b0;
      end else begin
        sout       <= shreg[FRAME-1];
        shreg      <= {shreg[FRAME-2:0], 1'b0};
        cnt        <= cnt_next;
        sout_valid <= 1'b1;
        sout_last  <= (cnt_next == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx; expected frames are hand-written constants,
// with parity-extended variants selected by PISO_PARITY_EN.
module tb_piso_shift_tx;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_last;

  int vectors;
  int miscompares;

  piso_shift_tx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sout_last (sout_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    din_valid = 1'b1;
    din = 8'hFF;
    repeat (3) step();
    got = {sout_valid, sout_last, sout, din_ready};
    vectors++;
    if (got !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", got, 4'b0001);
    end
    rst = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {sout_valid, sout_last, sout, din_ready};
      vectors++;
      if (got !== 4'b0001) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i, got, 4'b0001);
      end
    end
  endtask

  task automatic test_single_word();
    logic [FRAME-1:0] exp;
    logic [3:0]       got, want;
`ifdef PISO_PARITY_EN
    exp = 9'b101001010;
`else
    exp = 8'b10100101;
`endif
    din = 8'hA5;
    din_valid = 1'b1;
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 1", din_ready);
    end
    step();
    din_valid = 1'b0;
    din = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      want = {1'b1, i == FRAME - 1, exp[FRAME-1-i], i == FRAME - 1};
      got  = {sout_valid, sout_last, sout, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL single_bit[%0d]: got %b expected %b", i, got, want);
      end
      step();
    end
    got = {sout_valid, sout_last, sout, din_ready};
    vectors++;
    if (got !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_end: got %b expected %b", got, 4'b0001);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*FRAME-1:0] exp;
    logic [3:0]         got, want;
`ifdef PISO_PARITY_EN
    exp = 18'b100000010_001111000;
`else
    exp = 16'b10000001_00111100;
`endif
    din = 8'h81;
    din_valid = 1'b1;
    step();
    din = 8'h3C;
    for (int i = 0; i < 2 * FRAME; i++) begin
      want = {1'b1, (i == FRAME - 1) || (i == 2 * FRAME - 1), exp[2*FRAME-1-i],
              (i == FRAME - 1) || (i == 2 * FRAME - 1)};
      got  = {sout_valid, sout_last, sout, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b_bit[%0d]: got %b expected %b", i, got, want);
      end
      if (i == FRAME) din_valid = 1'b0;
      step();
    end
    got = {sout_valid, sout_last, sout, din_ready};
    vectors++;
    if (got !== 4'b0001) begin
      miscompares++;
      $display("FAIL b2b_end: got %b expected %b", got, 4'b0001);
    end
  endtask

  task automatic test_backpressure();
    logic [2*FRAME-1:0] exp;
    logic [3:0]         got, want;
`ifdef PISO_PARITY_EN
    exp = 18'b110000110_010110100;
`else
    exp = 16'b11000011_01011010;
`endif
    din = 8'hC3;
    din_valid = 1'b1;
    step();
    for (int i = 0; i < 2 * FRAME; i++) begin
      want = {1'b1, (i == FRAME - 1) || (i == 2 * FRAME - 1), exp[2*FRAME-1-i],
              (i == FRAME - 1) || (i == 2 * FRAME - 1)};
      got  = {sout_valid, sout_last, sout, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL bp_bit[%0d]: got %b expected %b", i, got, want);
      end
      if (i == FRAME - 1) din = 8'h5A;
      else if (i < FRAME - 1) din = 8'hE0 | 8'(i * 3 + 1);
      else din_valid = 1'b0;
      step();
    end
    got = {sout_valid, sout_last, sout, din_ready};
    vectors++;
    if (got !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_end: got %b expected %b", got, 4'b0001);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [FRAME-1:0] exp;
    logic [3:0]       got, want;
    din = 8'hF0;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      want = {3'b101, 1'b0};
      got  = {sout_valid, sout_last, sout, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL abort_bit[%0d]: got %b expected %b", i, got, want);
      end
      if (i == 3) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    got = {sout_valid, sout_last, sout, din_ready};
    vectors++;
    if (got !== 4'b0001) begin
      miscompares++;
      $display("FAIL abort_after_rst: got %b expected %b", got, 4'b0001);
    end
    step();
    got = {sout_valid, sout_last, sout, din_ready};
    vectors++;
    if (got !== 4'b0001) begin
      miscompares++;
      $display("FAIL abort_no_resume: got %b expected %b", got, 4'b0001);
    end
`ifdef PISO_PARITY_EN
    exp = 9'b000011110;
`else
    exp = 8'b00001111;
`endif
    din = 8'h0F;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      want = {1'b1, i == FRAME - 1, exp[FRAME-1-i], i == FRAME - 1};
      got  = {sout_valid, sout_last, sout, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL abort_next_bit[%0d]: got %b expected %b", i, got, want);
      end
      step();
    end
    got = {sout_valid, sout_last, sout, din_ready};
    vectors++;
    if (got !== 4'b0001) begin
      miscompares++;
      $display("FAIL abort_next_end: got %b expected %b", got, 4'b0001);
    end
  endtask

  task automatic test_parity();
    logic [FRAME-1:0] exp [2];
    logic [7:0]       words [2];
    logic [3:0]       got, want;
    words[0] = 8'h07;
    words[1] = 8'h03;
`ifdef PISO_PARITY_EN
    exp[0] = 9'b000001111;
    exp[1] = 9'b000000110;
`else
    exp[0] = 8'b00000111;
    exp[1] = 8'b00000011;
`endif
    for (int w = 0; w < 2; w++) begin
      din = words[w];
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        want = {1'b1, i == FRAME - 1, exp[w][FRAME-1-i], i == FRAME - 1};
        got  = {sout_valid, sout_last, sout, din_ready};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL parity_w%0d_bit[%0d]: got %b expected %b", w, i, got, want);
        end
        step();
      end
      got = {sout_valid, sout_last, sout, din_ready};
      vectors++;
      if (got !== 4'b0001) begin
        miscompares++;
        $display("FAIL parity_w%0d_end: got %b expected %b", w, got, 4'b0001);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
